// File: rtl/mc_controller.sv
// Multicycle ARM control unit: FSM sequencing, ALU decode, NZCV flags, cond gating.
// Define MC_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_controller #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  state_o
`ifdef MC_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state;
  state_t next;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign cmd       = funct[4:1];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  logic [3:0] flags;
  logic       cond_q;
  logic       cond_ex;

  logic alu_add;
  logic alu_sub;
  logic alu_and;
  logic alu_orr;
  logic cmd_ok;
  logic [1:0] alu_ctl;

  assign alu_add = (cmd == 4'b0100);
  assign alu_sub = (cmd == 4'b0010);
  assign alu_and = (cmd == 4'b0000);
  assign alu_orr = (cmd == 4'b1100);
  assign cmd_ok  = alu_add | alu_sub | alu_and | alu_orr;

  always_comb begin
    alu_ctl = 2'b00;
    unique case (1'b1)
      alu_sub: alu_ctl = 2'b01;
      alu_and: alu_ctl = 2'b10;
      alu_orr: alu_ctl = 2'b11;
      default: alu_ctl = 2'b00;
    endcase
  end

  logic fn;
  logic fz;
  logic fc;
  logic fv;

  assign {fn, fz, fc, fv} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0:    cond_ex = fz;
      4'h1:    cond_ex = ~fz;
      4'h2:    cond_ex = fc;
      4'h3:    cond_ex = ~fc;
      4'h4:    cond_ex = fn;
      4'h5:    cond_ex = ~fn;
      4'h6:    cond_ex = fv;
      4'h7:    cond_ex = ~fv;
      4'h8:    cond_ex = fc & ~fz;
      4'h9:    cond_ex = ~fc | fz;
      4'hA:    cond_ex = (fn == fv);
      4'hB:    cond_ex = (fn != fv);
      4'hC:    cond_ex = ~fz & (fn == fv);
      4'hD:    cond_ex = fz | (fn != fv);
      4'hE:    cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       ir_w;
  logic       pc_f;
  logic       exec;
  logic       adr;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] alu_c;
  logic [1:0] res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next   = state;
    reg_w  = 1'b0;
    mem_w  = 1'b0;
    branch = 1'b0;
    ir_w   = 1'b0;
    pc_f   = 1'b0;
    exec   = 1'b0;
    adr    = 1'b0;
    src_a  = 2'b00;
    src_b  = 2'b00;
    alu_c  = 2'b00;
    res    = 2'b00;
    unique case (state)
      FETCH: begin
        src_a = 2'b01;
        src_b = 2'b10;
        res   = 2'b10;
        ir_w  = mem_ready;
        pc_f  = mem_ready;
        if (mem_ready) next = DECODE;
      end
      DECODE: begin
        src_a = 2'b01;
        src_b = 2'b10;
        res   = 2'b10;
        case (op)
          2'b01:   next = MEMADR;
          2'b00:   next = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        src_b = 2'b01;
        next  = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr = 1'b1;
        if (mem_ready) next = MEMWB;
      end
      MEMWB: begin
        res   = 2'b01;
        reg_w = 1'b1;
        next  = FETCH;
      end
      MEMWRITE: begin
        adr   = 1'b1;
        mem_w = 1'b1;
        if (mem_ready) next = FETCH;
      end
      EXECUTER: begin
        exec  = 1'b1;
        alu_c = alu_ctl;
        next  = ALUWB;
      end
      EXECUTEI: begin
        exec  = 1'b1;
        src_b = 2'b01;
        alu_c = alu_ctl;
        next  = ALUWB;
      end
      ALUWB: begin
        // unsupported cmd runs as a harmless ADD with no writeback
        reg_w = cmd_ok;
        next  = FETCH;
      end
      BRANCH: begin
        src_a  = 2'b10;
        src_b  = 2'b01;
        res    = 2'b10;
        branch = 1'b1;
        next   = FETCH;
      end
      default: next = FETCH;
    endcase
  end

  logic flag_nz;
  logic flag_cv;

  assign flag_nz = exec & cond_q & cmd_ok & funct[0];
  assign flag_cv = flag_nz & (alu_add | alu_sub);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags  <= FLAG_RESET;
      cond_q <= 1'b0;
    end else begin
      if (state == DECODE) cond_q <= cond_ex;
      if (flag_nz) flags[3:2] <= ALUFlags[3:2];
      if (flag_cv) flags[1:0] <= ALUFlags[1:0];
    end
  end

  logic rf_we;

  assign rf_we = reg_w & cond_q;

  assign PCWrite  = reset & (pc_f | (branch & cond_q)
                    | (rf_we & (rd == 4'hF)));
  assign IRWrite  = reset & ir_w;
  assign MemWrite = reset & mem_w & cond_q;
  assign RegWrite = reset & rf_we;

  assign AdrSrc     = reset & adr;
  assign ALUSrcA    = reset ? src_a : 2'b00;
  assign ALUSrcB    = reset ? src_b : 2'b00;
  assign ALUControl = reset ? alu_c : 2'b00;
  assign ResultSrc  = reset ? res : 2'b00;
  assign ImmSrc     = reset ? op : 2'b00;
  assign RegSrc     = reset ? {op == 2'b01, op == 2'b10} : 2'b00;
  assign state_o    = state;

`ifdef MC_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state != FETCH && next == FETCH) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle ARM control unit; successor to the single-cycle controller.
- Sequences a shared-memory, single-ALU datapath through FETCH/DECODE/EXECUTE/writeback states.
- Decodes Instr[31:12], holds the NZCV flag register, evaluates condition codes, and stalls on a memory-ready handshake.
- Sits between the instruction register and the multicycle datapath muxes/enables.

Parameters:
- FLAG_RESET, 4'b0000, reset value of the {N,Z,C,V} flag register

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- Instr  in  20  Instr[31:12] from the instruction register (cond[31:28], op[27:26], funct[25:20], Rd[15:12])
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- mem_ready  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register file write enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUResult
- RegSrc  out  2  [0]: Rn := R15 when op=10; [1]: Rm := Rd when op=01
- ImmSrc  out  2  equal to op
- ALUSrcA  out  2  00 = RD1, 01 = PC, 10 = ALUOut
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- state_o  out  4  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- Reset (async, reset=0):
  - state=FETCH, flags=FLAG_RESET, cond_q=0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 while reset is low.
  - All mux selects are 0 while reset is low.
  - Reset mid-instruction abandons that instruction; no partial writes occur.
- Transitions:
  - FETCH→DECODE only when mem_ready=1; otherwise stay.
  - DECODE on op:
    - op=01 → MEMADR
    - op=00 and funct[5]=0 → EXECUTER
    - op=00 and funct[5]=1 → EXECUTEI
    - op=10 → BRANCH
    - op=11 → FETCH (undefined; NOP)
  - MEMADR: funct[0]=1 → MEMREAD; funct[0]=0 → MEMWRITE.
  - MEMREAD→MEMWB when mem_ready=1; otherwise stay.
  - MEMWRITE→FETCH when mem_ready=1; otherwise stay.
  - MEMWB, ALUWB and BRANCH → FETCH.
  - EXECUTER and EXECUTEI → ALUWB.
- Moore outputs per state (unlisted outputs = 0):
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, IRWrite=mem_ready, PCWrite=mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW.
  - MEMWRITE: AdrSrc=1, MemW; held high until mem_ready.
  - EXECUTER: ALUSrcB=00, ALU decode active.
  - EXECUTEI: ALUSrcB=01, ALU decode active.
  - ALUWB: ResultSrc=00, RegW.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, Branch.
- ALU decode (EXECUTE states only):
  - cmd = funct[4:1]: 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR; any other cmd → ADD with no writes (RegW and flag writes suppressed).
  - FlagW[1] (updates N,Z) = funct[0].
  - FlagW[0] (updates C,V) = funct[0] & (ADD|SUB).
- Condition logic:
  - CondEx is evaluated from cond and the flag register during DECODE and latched into cond_q at the DECODE→next transition.
  - Later states of the same instruction use cond_q, so a flag update in EXECUTE cannot change that instruction's own writeback.
  - cond codes 0000–1110 follow the ARM table (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL); 1111 → false.
- Write gating:
  - RegWrite = RegW & cond_q.
  - MemWrite = MemW & cond_q.
  - PCWrite additionally = (Branch & cond_q) | (RegW & cond_q & Rd==4'hF).
  - Flags are written at the end of EXECUTER/EXECUTEI when cond_q=1 and the matching FlagW bit is set, taken from ALUFlags that cycle.
- Instruction length: 3 cycles (branch), 4 cycles (ALU, STR), 5 cycles (LDR), plus mem_ready wait cycles.

Optional Feature:
- Macro MC_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - Both reset to 0.
  - cycle_cnt increments every clock out of reset.
  - instr_cnt increments on each entry to FETCH from a non-FETCH state, including annulled instructions.
  - Both wrap 0xFFFFFFFF→0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset low mid-EXECUTER → state_o=0 and all enables 0 immediately; after release, FETCH with mem_ready=1 → IRWrite=1, PCWrite=1.
- ADDS R1 (Instr=0xE091_1, cond=E, op=00, funct=001001), ALUFlags=0100 → states 0,1,6,8,0; RegWrite=1 in ALUWB; flags=0100 afterwards.
- LDR with mem_ready low 2 cycles in MEMREAD → MEMREAD held 3 cycles, RegWrite only in MEMWB, ResultSrc=01.
- BEQ with Z=0 → BRANCH state reached, PCWrite=0 there; with Z=1 → PCWrite=1, ALUSrcA=10.
- SUBS in EXECUTE sets Z=1; verify cond_q latched in DECODE governs that instruction's ALUWB; the next EQ instruction executes.
- op=11 → FETCH, DECODE, FETCH with no write enables; with MC_PERF_EN, instr_cnt +1 and cycle_cnt +2.
